// File: rtl/boron_pkg.sv
// Shared Boron definitions: widths, round constants, FSM encoding and the P-layer/S-box helpers.
package boron_pkg;

    localparam int unsigned BLOCK_W    = 64;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned NIBBLES    = BLOCK_W / NIB_W;
    localparam int unsigned DEF_ROUNDS = 25;
    localparam int unsigned DEF_KIDX_W = 5;

    // Per-word rotate amounts of the P-layer (left for encrypt, right for decrypt)
    localparam int unsigned ROT_W0 = 1;
    localparam int unsigned ROT_W1 = 4;
    localparam int unsigned ROT_W2 = 7;
    localparam int unsigned ROT_W3 = 9;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [NIB_W-1:0]   nib_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Rotate a 16-bit word left by a nonzero constant amount
    function automatic word_t rotl16(input word_t w, input int unsigned n);
        return word_t'((w << n) | (w >> (WORD_W - n)));
    endfunction

    // Rotate a 16-bit word right by a nonzero constant amount
    function automatic word_t rotr16(input word_t w, input int unsigned n);
        return word_t'((w >> n) | (w << (WORD_W - n)));
    endfunction

    // Decryption S-box (inverse of the Boron encryption S-box)
    function automatic nib_t dec_sbox(input nib_t n);
        nib_t r;
        case (n)
            4'h0:    r = 4'hA;
            4'h1:    r = 4'h3;
            4'h2:    r = 4'h9;
            4'h3:    r = 4'hE;
            4'h4:    r = 4'h1;
            4'h5:    r = 4'hD;
            4'h6:    r = 4'hF;
            4'h7:    r = 4'h4;
            4'h8:    r = 4'hC;
            4'h9:    r = 4'h5;
            4'hA:    r = 4'h7;
            4'hB:    r = 4'h2;
            4'hC:    r = 4'h6;
            4'hD:    r = 4'h8;
            4'hE:    r = 4'h0;
            default: r = 4'hB;
        endcase
        return r;
    endfunction

    // Inverse P-layer: undo the word XOR chain, rotate right, then swap word pairs
    function automatic block_t inv_player(input block_t b);
        word_t w3, w2, w1, w0;
        word_t t3, t2, t1, t0;
        w3 = b[63:48];
        w2 = b[47:32];
        w1 = b[31:16];
        w0 = b[15:0];
        t3 = w3 ^ w2;
        t2 = w2 ^ w1;
        t1 = w1 ^ w0;
        t0 = w0;
        t0 = rotr16(t0, ROT_W0);
        t1 = rotr16(t1, ROT_W1);
        t2 = rotr16(t2, ROT_W2);
        t3 = rotr16(t3, ROT_W3);
        return {t2, t3, t0, t1};
    endfunction

    // Forward P-layer used by the encrypt side: swap word pairs, rotate left, chain XOR upward
    function automatic block_t player(input block_t b);
        word_t s3, s2, s1, s0;
        s3 = b[47:32];
        s2 = b[63:48];
        s1 = b[15:0];
        s0 = b[31:16];
        s0 = rotl16(s0, ROT_W0);
        s1 = rotl16(s1, ROT_W1);
        s2 = rotl16(s2, ROT_W2);
        s3 = rotl16(s3, ROT_W3);
        s1 = s1 ^ s0;
        s2 = s2 ^ s1;
        s3 = s3 ^ s2;
        return {s3, s2, s1, s0};
    endfunction

endpackage

// File: rtl/boron_dec_core_if.sv
// Stream and key-store signals of the Boron decryption engine.
interface boron_dec_core_if
    import boron_pkg::*;
#(
    parameter int unsigned KIDX_W = DEF_KIDX_W
);

    block_t              ct_i;
    logic                in_valid;
    logic                in_ready;
    logic [KIDX_W-1:0]   rk_idx;
    block_t              rk_i;
    block_t              pt_o;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    // Engine side
    modport slave (
        input  ct_i,
        input  in_valid,
        output in_ready,
        output rk_idx,
        input  rk_i,
        output pt_o,
        output out_valid,
        input  out_ready,
        output busy
    );

    // Source / sink / key-store side
    modport master (
        output ct_i,
        output in_valid,
        input  in_ready,
        input  rk_idx,
        output rk_i,
        input  pt_o,
        input  out_valid,
        output out_ready,
        input  busy
    );

endinterface

// File: rtl/boron_dec_round.sv
// One Boron decryption round: inverse P-layer, 16 inverse S-boxes, round-key XOR.
module boron_dec_round
    import boron_pkg::*;
(
    input  block_t i_state,
    input  block_t i_rk,
    output block_t o_state_c
);

    block_t w_perm;
    block_t w_sub;

    // Word-level permutation first
    assign w_perm = inv_player(i_state);

    // Sixteen parallel nibble substitutions
    for (genvar g = 0; g < NIBBLES; g++) begin : g_sbox
        assign w_sub[NIB_W*g +: NIB_W] = dec_sbox(w_perm[NIB_W*g +: NIB_W]);
    end

    // Key whitening closes the round
    assign o_state_c = w_sub ^ i_rk;

endmodule

// File: rtl/boron_dec_core.sv
// Iterative Boron decryption engine: one 64-bit block, one round per clock.
module boron_dec_core
    import boron_pkg::*;
#(
    parameter int unsigned ROUNDS = DEF_ROUNDS,
    parameter int unsigned KIDX_W = DEF_KIDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    boron_dec_core_if.slave  bus
);

    localparam logic [KIDX_W-1:0] KIDX_LAST  = KIDX_W'(ROUNDS);
    localparam logic [KIDX_W-1:0] KIDX_FIRST = KIDX_W'(ROUNDS - 1);

    fsm_e               r_fsm;
    block_t             r_state;
    logic [KIDX_W-1:0]  r_ctr;
    logic [KIDX_W-1:0]  r_rk_idx;
    block_t             r_pt;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_busy;

    block_t             w_round_c;
    logic               w_last;

    // Datapath for the round the key store is currently serving
    boron_dec_round u_round (
        .i_state   (r_state),
        .i_rk      (bus.rk_i),
        .o_state_c (w_round_c)
    );

    assign w_last = (r_ctr == '0);

    // Sequencer: accept a block, run ROUNDS rounds, hold the result until the sink takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_ctr       <= '0;
            r_rk_idx    <= KIDX_LAST;
            r_pt        <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Key K[ROUNDS] is on rk_i while idle: pre-whiten the ciphertext
                        r_state    <= bus.ct_i ^ bus.rk_i;
                        r_ctr      <= KIDX_FIRST;
                        r_rk_idx   <= KIDX_FIRST;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_fsm      <= RUN;
                    end
                end
                RUN: begin
                    r_state <= w_round_c;
                    if (w_last) begin
                        r_pt        <= w_round_c;
                        r_out_valid <= 1'b1;
                        r_rk_idx    <= '0;
                        r_fsm       <= DONE;
                    end else begin
                        r_ctr    <= r_ctr - 1'b1;
                        r_rk_idx <= r_ctr - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_rk_idx    <= KIDX_LAST;
                        r_fsm       <= IDLE;
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

    // Registered outputs onto the bus
    assign bus.in_ready  = r_in_ready;
    assign bus.rk_idx    = r_rk_idx;
    assign bus.pt_o      = r_pt;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;

endmodule
